// File: rtl/host_cmd_dec.sv
// Host command/parameter decoder: synchronizes the 8080-style host write port and
// turns command and parameter bytes into single-cycle register write strobes.
module host_cmd_dec #(
    parameter int          SYNC_STAGES = 2,
    parameter int          NPARAM      = 8,
    parameter logic [7:0]  CMD_SYSSET  = 8'h40
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       hst_cs_x,
    input  logic       hst_wr_x,
    input  logic       hst_a0,
    input  logic [7:0] hst_d,
    output logic       reg_0x00_ce,
    output logic       reg_0x01_ce,
    output logic       reg_0x02_ce,
    output logic       reg_0x03_ce,
    output logic       reg_0x04_ce,
    output logic       reg_0x05_ce,
    output logic       reg_0x06_ce,
    output logic       reg_0x07_ce,
    output logic       reg_wrreq,
    output logic [7:0] reg_wdata,
    output logic [7:0] cmd_code,
    output logic       cmd_valid
);

    localparam logic [2:0] LAST_IDX = 3'(NPARAM - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PARAM = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] wr_sync_r;
    logic [SYNC_STAGES-1:0] a0_sync_r;
    logic [7:0]             d_sync_r [SYNC_STAGES];

    logic       cs_prev_r;
    logic       wr_prev_r;
    logic       a0_prev_r;
    logic [7:0] d_prev_r;

    logic       event_s;
    logic       cmd_ev_s;
    logic       par_ev_s;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] idx_r;
    logic [2:0] idx_nxt_s;

    logic [7:0] ce_nxt_s;
    logic       wrreq_nxt_s;
    logic [7:0] wdata_nxt_s;
    logic [7:0] cmd_code_nxt_s;
    logic       cmd_valid_nxt_s;

    logic [7:0] ce_r;
    logic       wrreq_r;
    logic [7:0] wdata_r;
    logic [7:0] cmd_code_r;
    logic       cmd_valid_r;

    // Synchronizer chains; all bits share the same depth so data stays aligned with strobes
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cs_sync_r <= {SYNC_STAGES{1'b1}};
            wr_sync_r <= {SYNC_STAGES{1'b1}};
            a0_sync_r <= {SYNC_STAGES{1'b0}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                d_sync_r[i] <= 8'h00;
            end
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], hst_cs_x};
            wr_sync_r   <= {wr_sync_r[SYNC_STAGES-2:0], hst_wr_x};
            a0_sync_r   <= {a0_sync_r[SYNC_STAGES-2:0], hst_a0};
            d_sync_r[0] <= hst_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                d_sync_r[i] <= d_sync_r[i-1];
            end
        end
    end

    // One-cycle history of the synchronized host bus for WR# rising-edge detection
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cs_prev_r <= 1'b1;
            wr_prev_r <= 1'b1;
            a0_prev_r <= 1'b0;
            d_prev_r  <= 8'h00;
        end else begin
            cs_prev_r <= cs_sync_r[SYNC_STAGES-1];
            wr_prev_r <= wr_sync_r[SYNC_STAGES-1];
            a0_prev_r <= a0_sync_r[SYNC_STAGES-1];
            d_prev_r  <= d_sync_r[SYNC_STAGES-1];
        end
    end

    // The event qualifies with chip select as it was while WR# was still low
    assign event_s  = wr_sync_r[SYNC_STAGES-1] & ~wr_prev_r & ~cs_prev_r;
    assign cmd_ev_s = event_s & a0_prev_r;
    assign par_ev_s = event_s & ~a0_prev_r;

    // State register
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic; a command in any state restarts or aborts the parameter sequence
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        if (cmd_ev_s) begin
            idx_nxt_s = 3'd0;
            if (d_prev_r == CMD_SYSSET) begin
                state_nxt_s = ST_PARAM;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (par_ev_s) begin
            case (state_r)
                ST_PARAM: begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = state_r;
                    idx_nxt_s   = idx_r;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            idx_nxt_s   = idx_r;
        end
    end

    // Output decode; values are registered below so they appear one clock after the event
    always_comb begin
        ce_nxt_s        = 8'h00;
        wrreq_nxt_s     = 1'b0;
        wdata_nxt_s     = wdata_r;
        cmd_code_nxt_s  = cmd_code_r;
        cmd_valid_nxt_s = 1'b0;
        if (cmd_ev_s) begin
            cmd_code_nxt_s  = d_prev_r;
            cmd_valid_nxt_s = 1'b1;
        end else if (par_ev_s) begin
            case (state_r)
                ST_PARAM: begin
                    ce_nxt_s    = 8'h01 << idx_r;
                    wrreq_nxt_s = 1'b1;
                    wdata_nxt_s = d_prev_r;
                end
                default: begin
                    ce_nxt_s    = 8'h00;
                    wrreq_nxt_s = 1'b0;
                end
            endcase
        end else begin
            ce_nxt_s    = 8'h00;
            wrreq_nxt_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            ce_r        <= 8'h00;
            wrreq_r     <= 1'b0;
            wdata_r     <= 8'h00;
            cmd_code_r  <= 8'h00;
            cmd_valid_r <= 1'b0;
        end else begin
            ce_r        <= ce_nxt_s;
            wrreq_r     <= wrreq_nxt_s;
            wdata_r     <= wdata_nxt_s;
            cmd_code_r  <= cmd_code_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
        end
    end

    assign reg_0x00_ce = ce_r[0];
    assign reg_0x01_ce = ce_r[1];
    assign reg_0x02_ce = ce_r[2];
    assign reg_0x03_ce = ce_r[3];
    assign reg_0x04_ce = ce_r[4];
    assign reg_0x05_ce = ce_r[5];
    assign reg_0x06_ce = ce_r[6];
    assign reg_0x07_ce = ce_r[7];
    assign reg_wrreq   = wrreq_r;
    assign reg_wdata   = wdata_r;
    assign cmd_code    = cmd_code_r;
    assign cmd_valid   = cmd_valid_r;

endmodule

// File: tb/tb_host_cmd_dec.sv
// Testbench for host_cmd_dec: two instances (NPARAM=8 and NPARAM=3) share one host bus and
// are checked against a transaction-level protocol model after every host write.
module tb_host_cmd_dec;

    logic       clk = 1'b0;
    logic       rst_x = 1'b0;
    logic       hst_cs_x = 1'b1;
    logic       hst_wr_x = 1'b1;
    logic       hst_a0 = 1'b0;
    logic [7:0] hst_d = 8'h00;

    logic [7:0] ce0, ce1, wd0, wd1, cc0, cc1;
    logic       wr0, wr1, cv0, cv1;

    int errors = 0;
    int checks = 0;

    // reference model state, index 0 = NPARAM 8, index 1 = NPARAM 3
    int         nparam [2] = '{8, 3};
    bit         in_param [2];
    int         pidx [2];
    logic [7:0] last_wd [2];
    logic [7:0] last_cc [2];

    always #5 clk = ~clk;

    host_cmd_dec #(.SYNC_STAGES(2), .NPARAM(8), .CMD_SYSSET(8'h40)) dut (
        .clk(clk), .rst_x(rst_x), .hst_cs_x(hst_cs_x), .hst_wr_x(hst_wr_x),
        .hst_a0(hst_a0), .hst_d(hst_d),
        .reg_0x00_ce(ce0[0]), .reg_0x01_ce(ce0[1]), .reg_0x02_ce(ce0[2]), .reg_0x03_ce(ce0[3]),
        .reg_0x04_ce(ce0[4]), .reg_0x05_ce(ce0[5]), .reg_0x06_ce(ce0[6]), .reg_0x07_ce(ce0[7]),
        .reg_wrreq(wr0), .reg_wdata(wd0), .cmd_code(cc0), .cmd_valid(cv0)
    );

    host_cmd_dec #(.SYNC_STAGES(2), .NPARAM(3), .CMD_SYSSET(8'h40)) dut3 (
        .clk(clk), .rst_x(rst_x), .hst_cs_x(hst_cs_x), .hst_wr_x(hst_wr_x),
        .hst_a0(hst_a0), .hst_d(hst_d),
        .reg_0x00_ce(ce1[0]), .reg_0x01_ce(ce1[1]), .reg_0x02_ce(ce1[2]), .reg_0x03_ce(ce1[3]),
        .reg_0x04_ce(ce1[4]), .reg_0x05_ce(ce1[5]), .reg_0x06_ce(ce1[6]), .reg_0x07_ce(ce1[7]),
        .reg_wrreq(wr1), .reg_wdata(wd1), .cmd_code(cc1), .cmd_valid(cv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            in_param[k] = 1'b0;
            pidx[k]     = 0;
            last_wd[k]  = 8'h00;
            last_cc[k]  = 8'h00;
        end
    endtask

    // Raise WR#, watch both instances for the response window, then compare with the model
    task automatic finish_write(input logic a0, input logic [7:0] d, input logic cs);
        int         n_wr [2];
        int         n_cv [2];
        int         lat [2];
        int         stray [2];
        logic [7:0] ce_at [2];
        logic [7:0] wd_at [2];
        logic [7:0] cc_at [2];
        logic [7:0] ce_v, wd_v, cc_v;
        logic       wr_v, cv_v;
        bit         exp_strobe, exp_cmd;
        logic [7:0] exp_ce;
        for (int k = 0; k < 2; k++) begin
            n_wr[k] = 0; n_cv[k] = 0; lat[k] = 0; stray[k] = 0;
            ce_at[k] = 8'h00; wd_at[k] = 8'h00; cc_at[k] = 8'h00;
        end
        hst_wr_x = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ce_v = (k == 0) ? ce0 : ce1;
                wr_v = (k == 0) ? wr0 : wr1;
                wd_v = (k == 0) ? wd0 : wd1;
                cv_v = (k == 0) ? cv0 : cv1;
                cc_v = (k == 0) ? cc0 : cc1;
                if (wr_v) begin
                    n_wr[k]++;
                    ce_at[k] = ce_v;
                    wd_at[k] = wd_v;
                    lat[k]   = i;
                    if ($countones(ce_v) != 1) stray[k]++;
                end else if (ce_v != 8'h00) begin
                    stray[k]++;
                end
                if (cv_v) begin
                    n_cv[k]++;
                    cc_at[k] = cc_v;
                end
            end
        end
        hst_cs_x = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_strobe = 1'b0;
            exp_cmd    = 1'b0;
            exp_ce     = 8'h00;
            if (!cs) begin
                if (a0) begin
                    exp_cmd     = 1'b1;
                    last_cc[k]  = d;
                    in_param[k] = (d == 8'h40);
                    pidx[k]     = 0;
                end else if (in_param[k]) begin
                    exp_strobe = 1'b1;
                    exp_ce     = 8'(1 << pidx[k]);
                    last_wd[k] = d;
                    pidx[k]++;
                    if (pidx[k] == nparam[k]) begin
                        in_param[k] = 1'b0;
                        pidx[k]     = 0;
                    end
                end
            end
            chk($sformatf("i%0d_wrreq_count", k), 32'(n_wr[k]), 32'(exp_strobe));
            chk($sformatf("i%0d_cmdvalid_count", k), 32'(n_cv[k]), 32'(exp_cmd));
            chk($sformatf("i%0d_ce_stray", k), 32'(stray[k]), 32'd0);
            if (exp_strobe) begin
                chk($sformatf("i%0d_ce", k), 32'(ce_at[k]), 32'(exp_ce));
                chk($sformatf("i%0d_wdata_at_strobe", k), 32'(wd_at[k]), 32'(d));
                chk($sformatf("i%0d_latency_in_range", k), 32'(lat[k] >= 3 && lat[k] <= 4), 32'd1);
            end
            if (exp_cmd) begin
                chk($sformatf("i%0d_cmd_code_at_pulse", k), 32'(cc_at[k]), 32'(d));
            end
            chk($sformatf("i%0d_wdata_hold", k), 32'((k == 0) ? wd0 : wd1), 32'(last_wd[k]));
            chk($sformatf("i%0d_cmd_code_hold", k), 32'((k == 0) ? cc0 : cc1), 32'(last_cc[k]));
        end
    endtask

    task automatic host_write(input logic a0, input logic [7:0] d, input logic cs);
        @(negedge clk);
        hst_cs_x = cs;
        hst_a0   = a0;
        hst_d    = d;
        repeat (3) @(negedge clk);
        hst_wr_x = 1'b0;
        repeat (4) @(negedge clk);
        finish_write(a0, d, cs);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i0_outs"}, {ce0, wd0, cc0, 6'd0, wr0, cv0}, 32'd0);
        chk({tag, "_i1_outs"}, {ce1, wd1, cc1, 6'd0, wr1, cv1}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_x = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst_x = 1'b1;
    endtask

    task automatic sysset_seq();
        host_write(1'b1, 8'h40, 1'b0);
        for (int i = 1; i <= 8; i++) host_write(1'b0, 8'(i * 8'h11), 1'b0);
    endtask

    initial begin
        logic       ra0, rcs;
        logic [7:0] rd;
        int         r;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_initial");
        rst_x = 1'b1;
        repeat (2) @(negedge clk);

        // full SYSTEM SET sequence, then a ninth parameter that must be ignored
        sysset_seq();
        host_write(1'b0, 8'h99, 1'b0);

        // aborted sequence followed by an ignored parameter
        host_write(1'b1, 8'h40, 1'b0);
        host_write(1'b0, 8'hA1, 1'b0);
        host_write(1'b0, 8'hA2, 1'b0);
        host_write(1'b1, 8'h59, 1'b0);
        host_write(1'b0, 8'hA3, 1'b0);

        // deselected writes, then a valid sequence
        host_write(1'b1, 8'h40, 1'b1);
        host_write(1'b0, 8'h55, 1'b1);
        sysset_seq();

        // reset in the middle of a sequence
        host_write(1'b1, 8'h40, 1'b0);
        host_write(1'b0, 8'h01, 1'b0);
        host_write(1'b0, 8'h02, 1'b0);
        host_write(1'b0, 8'h03, 1'b0);
        pulse_reset();
        host_write(1'b0, 8'h77, 1'b0);
        host_write(1'b1, 8'h40, 1'b0);
        host_write(1'b0, 8'h77, 1'b0);

        // WR# already low while reset is released still yields a command event
        @(negedge clk);
        hst_cs_x = 1'b0; hst_a0 = 1'b1; hst_d = 8'h40; hst_wr_x = 1'b0;
        pulse_reset();
        hst_cs_x = 1'b0;
        repeat (4) @(negedge clk);
        finish_write(1'b1, 8'h40, 1'b0);
        host_write(1'b0, 8'h5A, 1'b0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r   = int'($urandom_range(0, 9));
            rcs = (r == 0);
            ra0 = (r <= 3);
            rd  = 8'($urandom);
            if (ra0 && ($urandom_range(0, 1) == 1)) rd = 8'h40;
            host_write(ra0, rd, rcs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
